// File: rtl/xor_stream_decipher.sv
// Receive side of the nibble XOR stream cipher: strips the LFSR keystream from
// incoming ciphertext nibbles and reassembles plaintext bytes, high nibble first.
module xor_stream_decipher #(
   parameter logic [3:0] SEED_ZERO_SUB = 4'b0001,
   parameter int         CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_load,
   input  logic [3:0]       key_in,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] byte_count,
   output logic             keyed
);

   typedef enum logic [1:0] {
      S_NOKEY = 2'd0,
      S_HI    = 2'd1,
      S_LO    = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [3:0]       lfsr_r;
   logic [3:0]       hi_r;
   logic             out_valid_r;
   logic [7:0]       out_data_r;
   logic [CNT_W-1:0] byte_count_r;
   logic             keyed_r;
   logic             in_ready_s;
   logic             accept_s;
   logic             deliver_s;
   logic [3:0]       plain_s;

   // x^4 + x^3 + 1 Fibonacci step, period 15 for any non-zero seed
   function automatic logic [3:0] lfsr_step(input logic [3:0] cur);
      return {cur[2:0], cur[3] ^ cur[2]};
   endfunction

   // An all-zero seed would lock the LFSR, so it is swapped for a fixed non-zero one
   function automatic logic [3:0] seed_of(input logic [3:0] key);
      return (key == 4'b0000) ? SEED_ZERO_SUB : key;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_NOKEY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; key_load overrides every handshake
   always_comb begin
      state_next_s = state_r;
      if (key_load) begin
         state_next_s = S_HI;
      end else begin
         case (state_r)
            S_NOKEY: state_next_s = S_NOKEY;
            S_HI:    state_next_s = accept_s  ? S_LO : S_HI;
            S_LO:    state_next_s = accept_s  ? S_OUT : S_LO;
            S_OUT:   state_next_s = deliver_s ? S_HI : S_OUT;
            default: state_next_s = S_NOKEY;
         endcase
      end
   end

   // Handshake qualifiers and keystream removal
   always_comb begin
      in_ready_s = ((state_r == S_HI) || (state_r == S_LO)) && !key_load && !rst;
      accept_s   = in_valid && in_ready_s;
      deliver_s  = (state_r == S_OUT) && out_valid_r && out_ready && !key_load && !rst;
      plain_s    = in_data ^ lfsr_r;
   end

   // Keystream, byte assembly and delivery bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_r       <= 4'b0000;
         hi_r         <= 4'b0000;
         out_valid_r  <= 1'b0;
         out_data_r   <= 8'h00;
         byte_count_r <= '0;
         keyed_r      <= 1'b0;
      end else if (key_load) begin
         lfsr_r       <= seed_of(key_in);
         out_valid_r  <= 1'b0;
         byte_count_r <= '0;
         keyed_r      <= 1'b1;
      end else begin
         if (accept_s) begin
            lfsr_r <= lfsr_step(lfsr_r);
            if (state_r == S_HI) begin
               hi_r <= plain_s;
            end else begin
               out_data_r  <= {hi_r, plain_s};
               out_valid_r <= 1'b1;
            end
         end
         if (deliver_s) begin
            out_valid_r  <= 1'b0;
            byte_count_r <= byte_count_r + CNT_W'(1);
         end
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign byte_count = byte_count_r;
   assign keyed      = keyed_r;

endmodule

// File: tb/tb_xor_stream_decipher.sv
// Directed and randomized bench for xor_stream_decipher; expected plaintext comes
// from an arithmetic keystream model kept here.
module tb_xor_stream_decipher;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_load = 1'b0;
   logic [3:0] key_in = 4'h0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b0;
   logic [7:0] byte_count;
   logic       keyed;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_ks;
   int m_count;

   xor_stream_decipher #(.SEED_ZERO_SUB(4'b0001), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .byte_count(byte_count), .keyed(keyed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // next keystream value: shift left, feed back bit3 xor bit2
   function automatic int ks_next(input int s);
      return ((s * 2) % 16) + (((s / 8) + (s / 4)) % 2);
   endfunction

   task automatic load_key(input logic [3:0] k);
      key_load = 1'b1;
      key_in   = k;
      #1;
      chk("in_ready_during_key_load", 16'(in_ready), 16'd0);
      tick();
      key_load = 1'b0;
      m_ks     = (k == 4'h0) ? 1 : int'(k);
      m_count  = 0;
      #1;
      chk("keyed_after_load", 16'(keyed), 16'd1);
      chk("count_after_load", 16'(byte_count), 16'd0);
      chk("out_valid_after_load", 16'(out_valid), 16'd0);
   endtask

   task automatic send_nibble(input logic [3:0] d, output logic [3:0] plain);
      bit got;
      got      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      chk("in_ready_wait", 16'(got), 16'd1);
      plain = d ^ 4'(m_ks);
      m_ks  = ks_next(m_ks);
      tick();
      in_valid = 1'b0;
      in_data  = 4'($urandom_range(0, 15));
   endtask

   task automatic send_byte(input logic [3:0] hi, input logic [3:0] lo, output logic [7:0] expb);
      logic [3:0] ph, pl;
      send_nibble(hi, ph);
      send_nibble(lo, pl);
      expb = {ph, pl};
      #1;
      chk("out_valid_latency", 16'(out_valid), 16'd1);
      chk("out_data_model", 16'(out_data), 16'(expb));
   endtask

   task automatic deliver();
      out_ready = 1'b1;
      #1;
      chk("out_valid_before_deliver", 16'(out_valid), 16'd1);
      tick();
      out_ready = 1'b0;
      m_count   = (m_count + 1) % 256;
      #1;
      chk("out_valid_after_deliver", 16'(out_valid), 16'd0);
      chk("byte_count", 16'(byte_count), 16'(m_count));
   endtask

   initial begin
      logic [7:0] b;
      logic [3:0] p;
      m_ks    = 0;
      m_count = 0;

      // reset, then no key: input ignored
      @(negedge clk);
      tick();
      tick();
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_out_data", 16'(out_data), 16'h00);
      chk("rst_keyed", 16'(keyed), 16'd0);
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'h3;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("nokey_in_ready", 16'(in_ready), 16'd0);
         chk("nokey_out_valid", 16'(out_valid), 16'd0);
         chk("nokey_keyed", 16'(keyed), 16'd0);
         chk("nokey_count", 16'(byte_count), 16'd0);
         tick();
      end
      in_valid = 1'b0;

      // basic decrypt
      load_key(4'b1010);
      send_byte(4'h0, 4'h0, b);
      chk("basic_A5", 16'(out_data), 16'h00A5);
      deliver();
      send_byte(4'h8, 4'hB, b);
      chk("basic_3C", 16'(out_data), 16'h003C);
      deliver();
      chk("basic_count2", 16'(byte_count), 16'd2);

      // zero key substitutes seed 0001
      load_key(4'h0);
      send_byte(4'hF, 4'hF, b);
      chk("zero_key_ED", 16'(out_data), 16'h00ED);
      deliver();

      // backpressure holds the byte and freezes the keystream
      load_key(4'b1010);
      send_byte(4'h0, 4'h0, b);
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 4'($urandom_range(0, 15));
         #1;
         chk("bp_out_data", 16'(out_data), 16'h00A5);
         chk("bp_out_valid", 16'(out_valid), 16'd1);
         chk("bp_in_ready", 16'(in_ready), 16'd0);
         tick();
      end
      in_valid = 1'b0;
      deliver();
      send_byte(4'h8, 4'hB, b);
      chk("bp_then_3C", 16'(out_data), 16'h003C);
      deliver();

      // key reload mid-byte drops the partial nibble
      load_key(4'b1010);
      send_nibble(4'h0, p);
      in_valid = 1'b1;
      in_data  = 4'h0;
      load_key(4'b1010);
      in_valid = 1'b0;
      send_byte(4'h0, 4'h0, b);
      chk("reload_A5", 16'(out_data), 16'h00A5);
      deliver();

      // randomized traffic with idle gaps and random backpressure
      load_key(4'($urandom_range(0, 15)));
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_byte(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), b);
         for (int s = $urandom_range(0, 3); s > 0; s--) begin
            tick();
            #1;
            chk("rand_hold", 16'(out_data), 16'(b));
         end
         deliver();
      end

      // counter wrap, then reset while a byte is pending
      load_key(4'($urandom_range(1, 15)));
      for (int n = 0; n < 256; n++) begin
         send_byte(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), b);
         deliver();
      end
      chk("wrap_count0", 16'(byte_count), 16'd0);
      send_byte(4'h1, 4'h2, b);
      rst = 1'b1;
      #1;
      chk("rst_in_ready_comb", 16'(in_ready), 16'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", 16'(out_valid), 16'd0);
      chk("midrst_keyed", 16'(keyed), 16'd0);
      chk("midrst_count", 16'(byte_count), 16'd0);
      in_valid = 1'b1;
      #1;
      chk("midrst_nokey_in_ready", 16'(in_ready), 16'd0);
      tick();
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
